// File: rtl/mpadder_seq.sv
// rtl/mpadder_seq.sv - digit-serial multi-precision adder/subtractor with start/done handshake
// Optional feature: define MPADDER_ZERO_FLAG_EN to add the registered `zero` output.

module mpadder_seq #(
  parameter int WIDTH = 1027,
  parameter int DIGIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
`ifdef MPADDER_ZERO_FLAG_EN
  output logic [WIDTH:0]   result,
  output logic             zero
`else
  output logic [WIDTH:0]   result
`endif
);

  // Number of digit slices covering the WIDTH+1 bit result: ceil((WIDTH+1)/DIGIT).
  localparam int NDIG = (WIDTH + DIGIT) / DIGIT;
  // Operand and result registers are padded to a whole number of digits.
  localparam int TOT  = NDIG * DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  logic [TOT-1:0]       op_a;
  logic [TOT-1:0]       op_b;
  logic [TOT-1:0]       acc;
  logic                 sub_q;
  logic                 carry;
  logic [CW-1:0]        cnt;
  logic [DIGIT:0]       sum_d;
  logic [TOT+DIGIT-1:0] acc_cat;
`ifdef MPADDER_ZERO_FLAG_EN
  logic                 nz;
`endif

  // One DIGIT-bit slice: b is inverted for subtraction, the +1 comes from the preloaded carry.
  always_comb begin
    sum_d = {1'b0, op_a[DIGIT-1:0]}
          + {1'b0, op_b[DIGIT-1:0] ^ {DIGIT{sub_q}}}
          + {{DIGIT{1'b0}}, carry};
  end

  // New digit enters at the MSB side; after NDIG shifts the LSB digit sits at bit 0.
  assign acc_cat = {sum_d[DIGIT-1:0], acc};
  assign result  = acc[WIDTH:0];

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      sub_q <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef MPADDER_ZERO_FLAG_EN
      nz    <= 1'b0;
      zero  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= {{(TOT-WIDTH){1'b0}}, in_a};
            op_b  <= {{(TOT-WIDTH){1'b0}}, in_b};
            sub_q <= subtract;
            carry <= subtract;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
`ifdef MPADDER_ZERO_FLAG_EN
            nz    <= 1'b0;
            zero  <= 1'b0;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc   <= acc_cat[TOT+DIGIT-1:DIGIT];
          carry <= sum_d[DIGIT];
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          cnt   <= cnt + 1'b1;
`ifdef MPADDER_ZERO_FLAG_EN
          // Padding bits above WIDTH are zero whenever the result is zero, so the full digit is OR-ed.
          nz    <= nz | (|sum_d[DIGIT-1:0]);
`endif
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
`ifdef MPADDER_ZERO_FLAG_EN
            zero  <= ~(nz | (|sum_d[DIGIT-1:0]));
`endif
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpadder_seq.sv
// tb/tb_mpadder_seq.sv - directed self-checking bench for mpadder_seq (default and WIDTH=8/DIGIT=3)

module tb_mpadder_seq;

  localparam int W  = 1027;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic          start = 1'b0, subtract = 1'b0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          busy, done;
  logic [W:0]    result;

  logic          s_start = 1'b0, s_subtract = 1'b0;
  logic [SW-1:0] s_a = '0, s_b = '0;
  logic          s_busy, s_done;
  logic [SW:0]   s_result;

`ifdef MPADDER_ZERO_FLAG_EN
  logic zero, s_zero;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mpadder_seq #(.WIDTH(W), .DIGIT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .busy(busy), .done(done),
`ifdef MPADDER_ZERO_FLAG_EN
    .zero(zero),
`endif
    .result(result)
  );

  mpadder_seq #(.WIDTH(SW), .DIGIT(3)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .subtract(s_subtract),
    .in_a(s_a), .in_b(s_b), .busy(s_busy), .done(s_done),
`ifdef MPADDER_ZERO_FLAG_EN
    .zero(s_zero),
`endif
    .result(s_result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed[1027:960]=%h observed[63:0]=%h expected[1027:960]=%h expected[63:0]=%h",
             tag, obs[W:960], obs[63:0], exp[W:960], exp[63:0]);
    end
  endtask

  // Launch one op on the wide DUT and stay in its done cycle (or give up after 40 cycles).
  task automatic run_big(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output int lat, output int busy_cnt);
    in_a = a; in_b = b; subtract = sub; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic run_small(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic sub,
                           output int lat);
    s_a = a; s_b = b; s_subtract = sub; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    lat = 1;
    while (!s_done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bc;
    logic [W:0] exp;
    logic [W:0] held;
    logic [W-1:0] big;
    logic [SW:0] sexp;
    int extra;

    // Reset state
    tick(); tick();
    chk("rst_busy", {{W{1'b0}}, busy}, '0);
    chk("rst_done", {{W{1'b0}}, done}, '0);
    chk("rst_result", result, '0);
`ifdef MPADDER_ZERO_FLAG_EN
    chk("rst_zero", {{W{1'b0}}, zero}, '0);
`endif
    reset = 1'b0;
    tick();

    // 1 + 1
    run_big(1, 1, 1'b0, lat, bc);
    chk("add11_lat", W'(lat), 18);
    chk("add11_busy_cycles", W'(bc), 17);
    chk("add11_result", result, 2);
    chk("add11_busy_in_done", {{W{1'b0}}, busy}, '0);

    // Back-to-back: start in the done cycle; carry ripples through every digit
    big = '1;
    run_big(big, 1, 1'b0, lat, bc);
    exp = '0; exp[W] = 1'b1;
    chk("b2b_lat", W'(lat), 18);
    chk("ripple_result", result, exp);
`ifdef MPADDER_ZERO_FLAG_EN
    chk("ripple_zero", {{W{1'b0}}, zero}, '0);
`endif

    // Borrow: 5 - 7 = -2
    run_big(5, 7, 1'b1, lat, bc);
    exp = '1; exp[0] = 1'b0;
    chk("borrow_result", result, exp);
    chk("borrow_sign", {{W{1'b0}}, result[W]}, 1);
`ifdef MPADDER_ZERO_FLAG_EN
    chk("borrow_zero", {{W{1'b0}}, zero}, '0);
`endif

    // Equal operands subtract to zero
    run_big(W'(16'hDEAD), W'(16'hDEAD), 1'b1, lat, bc);
    chk("eq_sub_result", result, '0);
`ifdef MPADDER_ZERO_FLAG_EN
    chk("eq_sub_zero", {{W{1'b0}}, zero}, 1);
`endif

    // Large positive difference: (2^1027-1) - 1
    run_big(big, 1, 1'b1, lat, bc);
    exp = '0; exp[W-1:0] = '1; exp[0] = 1'b0;
    chk("big_sub_result", result, exp);

    // Result is held after done while idle
    held = result;
    tick(); tick(); tick();
    chk("hold_result", result, held);
    chk("hold_done_low", {{W{1'b0}}, done}, '0);

    // start pulses during RUN are ignored; operand changes after accept have no effect
    in_a = 10; in_b = 20; subtract = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; in_a = 999; in_b = 7; subtract = 1'b1;
    lat = 1;
    while (!done && lat < 40) begin
      start = (lat == 3 || lat == 5 || lat == 9);
      tick();
      lat++;
    end
    start = 1'b0;
    chk("ign_lat", W'(lat), 18);
    chk("ign_result", result, 30);
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) extra++;
    end
    chk("ign_no_extra_done", W'(extra), 0);

    // Reset mid-RUN at T0+5
    in_a = 100; in_b = 23; subtract = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("midrst_busy", {{W{1'b0}}, busy}, '0);
    chk("midrst_done", {{W{1'b0}}, done}, '0);
    chk("midrst_result", result, '0);
    tick();
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) extra++;
    end
    chk("midrst_no_done", W'(extra), 0);
    run_big(100, 23, 1'b1, lat, bc);
    chk("post_rst_lat", W'(lat), 18);
    chk("post_rst_result", result, 77);

    // Small configuration: latency and a grid sweep against a 9-bit reference
    run_small(8'd255, 8'd255, 1'b0, lat);
    chk("small_lat", W'(lat), 4);
    chk("small_max_add", W'(s_result), 510);
    run_small(8'd0, 8'd255, 1'b1, lat);
    chk("small_min_sub", W'(s_result), 257);
    for (int i = 0; i < 18; i++) begin
      for (int j = 0; j < 18; j++) begin
        for (int m = 0; m < 2; m++) begin
          if (m == 0) sexp = 9'(i * 15 + j * 15);
          else        sexp = 9'(i * 15 - j * 15);
          run_small(8'(i * 15), 8'(j * 15), m[0], lat);
          chk("small_sweep", W'(s_result), W'(sexp));
`ifdef MPADDER_ZERO_FLAG_EN
          chk("small_sweep_zero", W'(s_zero), W'(sexp == 0));
`endif
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
